// File: rtl/host_spi_readout_pkg.sv
// host_spi_pkg: command codes, status/underrun words, FSM encoding and CRC-8 step for host_spi_readout.
// The CRC state only exists when HOST_SPI_CRC_EN is defined.
package host_spi_pkg;
  localparam logic [7:0]  CMD_READ      = 8'h01;
  localparam logic [7:0]  CMD_STATUS    = 8'h02;
  localparam logic [7:0]  STATUS_MAGIC  = 8'h5A;
  localparam logic [23:0] UNDERRUN_WORD = 24'hFFFFFF;
  localparam logic [7:0]  CRC_POLY      = 8'h07;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_LOAD = 3'd2,
    ST_DATA = 3'd3,
`ifdef HOST_SPI_CRC_EN
    ST_CRC  = 3'd5,
`endif
    ST_HOLD = 3'd4
  } state_e;
  // Host firmware decodes empty=bit0, underrun=bit1, full=bit2, abort=bit3.
  function automatic logic [23:0] status_word(input logic abort, input logic full,
                                              input logic underrun, input logic empty);
    return {STATUS_MAGIC, 12'h000, abort, full, underrun, empty};
  endfunction
  function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic din);
    return {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? CRC_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/host_spi_readout_if.sv
// host_spi_readout_if: read port of the sample FIFO; master = readout (pops), slave = FIFO.
interface host_spi_readout_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_rd_en;
  modport master (input fifo_data_out, input fifo_empty, input fifo_full, output fifo_rd_en);
  modport slave (output fifo_data_out, output fifo_empty, output fifo_full, input fifo_rd_en);
endinterface

// File: rtl/host_spi_readout_sync.sv
// host_spi_sync: multi-flop synchroniser with one-clk rise/fall pulses taken after the last stage.
module host_spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d_i);
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/host_spi_readout.sv
// host_spi_readout: mode-0 SPI slave that pops one FIFO word per READ frame or answers STATUS.
// Define HOST_SPI_CRC_EN to append a CRC-8 (poly 0x07, init 0) byte after the data phase.
module host_spi_readout
  import host_spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int CMD_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic host_sck,
  input  logic host_cs_n,
  input  logic host_mosi,
  output logic host_miso,
  output logic busy,
  host_spi_readout_if.master fifo
);
  localparam int CW = $clog2((DATA_WIDTH > CMD_WIDTH ? DATA_WIDTH : CMD_WIDTH) + 1);
  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_CMD  = ST_CMD;
  localparam logic [2:0] S_LOAD = ST_LOAD;
  localparam logic [2:0] S_DATA = ST_DATA;
  localparam logic [2:0] S_HOLD = ST_HOLD;
`ifdef HOST_SPI_CRC_EN
  localparam logic [2:0] S_CRC  = ST_CRC;
  logic [7:0] crc_q, crc_d;
`endif
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d, load_word;
  logic [1:0]             ld_q, ld_d;
  logic miso_q, miso_d, rd_en_q, rd_en_d, busy_q, busy_d, popped_q, popped_d;
  logic und_q, und_d, abt_q, abt_d, skip_q, skip_d;
  logic is_read, is_status, pop;
  host_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .d_i(host_sck), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  host_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d_i(host_cs_n), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  assign is_read   = cmd_q == CMD_WIDTH'(CMD_READ);
  assign is_status = cmd_q == CMD_WIDTH'(CMD_STATUS);
  assign pop       = is_read && !fifo.fifo_empty;
  assign load_word = popped_q  ? fifo.fifo_data_out :
                     is_read   ? DATA_WIDTH'(UNDERRUN_WORD) :
                     is_status ? DATA_WIDTH'(status_word(abt_q, fifo.fifo_full, und_q, fifo.fifo_empty)) :
                                 '0;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    shreg_d  = shreg_q;
    ld_d     = ld_q;
    miso_d   = miso_q;
    rd_en_d  = 1'b0;
    busy_d   = busy_q;
    popped_d = popped_q;
    und_d    = und_q;
    abt_d    = abt_q;
    skip_d   = skip_q;
`ifdef HOST_SPI_CRC_EN
    crc_d    = crc_q;
`endif
    if (cs_rise) begin
      state_d  = S_IDLE;
      miso_d   = 1'b0;
      busy_d   = 1'b0;
      popped_d = 1'b0;
      abt_d    = abt_q | (popped_q && (state_q == S_LOAD || state_q == S_DATA));
    end else begin
      case (state_q)
        S_IDLE: if (cs_fall) begin
          state_d  = S_CMD;
          cnt_d    = '0;
          miso_d   = 1'b0;
          busy_d   = 1'b1;
          popped_d = 1'b0;
        end
        S_CMD: if (sck_rise) begin
          cmd_d = {cmd_q[CMD_WIDTH-2:0], mosi_q[SYNC_STAGES-1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(CMD_WIDTH - 1)) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            ld_d    = 2'd0;
            skip_d  = 1'b1;
          end
        end
        // ld_q: 0 = decode (and pop), 1 = wait for FIFO word, 2 = load shift register.
        S_LOAD: begin
          skip_d = sck_fall ? 1'b0 : skip_q;
          if (ld_q == 2'd0) begin
            rd_en_d  = pop;
            popped_d = pop;
            ld_d     = pop ? 2'd1 : 2'd2;
          end else if (ld_q == 2'd1) begin
            ld_d = 2'd2;
          end else begin
            shreg_d = load_word;
            miso_d  = load_word[DATA_WIDTH-1];
            und_d   = !is_status && (und_q || (is_read && !popped_q));
            abt_d   = !is_status && abt_q;
            state_d = S_DATA;
`ifdef HOST_SPI_CRC_EN
            crc_d   = crc_step(8'h00, load_word[DATA_WIDTH-1]);
`endif
          end
        end
        S_DATA: if (sck_rise) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
`ifdef HOST_SPI_CRC_EN
            state_d = S_CRC;
`else
            state_d = S_HOLD;
            miso_d  = 1'b0;
`endif
          end
        end else if (sck_fall) begin
          skip_d = 1'b0;
          if (!skip_q) begin
            shreg_d = shreg_q << 1;
            miso_d  = shreg_q[DATA_WIDTH-2];
`ifdef HOST_SPI_CRC_EN
            crc_d   = crc_step(crc_q, shreg_q[DATA_WIDTH-2]);
`endif
          end
        end
`ifdef HOST_SPI_CRC_EN
        S_CRC: if (sck_rise) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(7)) begin
            cnt_d   = '0;
            state_d = S_HOLD;
            miso_d  = 1'b0;
          end
        end else if (sck_fall) begin
          miso_d = crc_q[7];
          crc_d  = crc_q << 1;
        end
`endif
        S_HOLD: miso_d = 1'b0;
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      mosi_q   <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      shreg_q  <= '0;
      ld_q     <= 2'd0;
      miso_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      popped_q <= 1'b0;
      und_q    <= 1'b0;
      abt_q    <= 1'b0;
      skip_q   <= 1'b0;
`ifdef HOST_SPI_CRC_EN
      crc_q    <= 8'h00;
`endif
    end else begin
      mosi_q   <= (mosi_q << 1) | SYNC_STAGES'(host_mosi);
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      shreg_q  <= shreg_d;
      ld_q     <= ld_d;
      miso_q   <= miso_d;
      rd_en_q  <= rd_en_d;
      busy_q   <= busy_d;
      popped_q <= popped_d;
      und_q    <= und_d;
      abt_q    <= abt_d;
      skip_q   <= skip_d;
`ifdef HOST_SPI_CRC_EN
      crc_q    <= crc_d;
`endif
    end
  end
  assign host_miso       = miso_q;
  assign busy            = busy_q;
  assign fifo.fifo_rd_en = rd_en_q;
endmodule
